// File: rtl/regfile_sb_pkg.sv
// Shared defaults and architectural register names for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;

  typedef enum logic [4:0] {
    x0,  x1,  x2,  x3,  x4,  x5,  x6,  x7,
    x8,  x9,  x10, x11, x12, x13, x14, x15,
    x16, x17, x18, x19, x20, x21, x22, x23,
    x24, x25, x26, x27, x28, x29, x30, x31
  } reg_name_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Read, issue and writeback bundle between the pipeline (master) and the register file (slave).
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                wb0_valid;
  logic [AW-1:0]       wb0_rd;
  logic [XLEN-1:0]     wb0_data;
  logic                wb1_valid;
  logic [AW-1:0]       wb1_rd;
  logic [XLEN-1:0]     wb1_data;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_addr, iss_valid, iss_rd,
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, iss_valid, iss_rd,
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: zero-register, writeback bypass (wb1 over wb0), then array.
module regfile_sb_rdport
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [$clog2(NREGS)-1:0] addr,
  input  logic [NREGS*XLEN-1:0]    regs,
  input  logic [NREGS-1:0]         busy_vec,
  input  logic                     wb0_valid,
  input  logic [$clog2(NREGS)-1:0] wb0_rd,
  input  logic [XLEN-1:0]          wb0_data,
  input  logic                     wb1_valid,
  input  logic [$clog2(NREGS)-1:0] wb1_rd,
  input  logic [XLEN-1:0]          wb1_data,
  output logic [XLEN-1:0]          data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(NREGS);

  logic hit0;
  logic hit1;
  logic [XLEN-1:0] arr_data;

  // array lookup by address
  always_comb begin
    arr_data = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (addr == AW'(i)) arr_data = regs[i*XLEN +: XLEN];
    end
  end

  // priority select; bypassed values are never reported busy
  always_comb begin
    hit0 = wb0_valid && (wb0_rd == addr);
    hit1 = wb1_valid && (wb1_rd == addr);
    data = arr_data;
    busy = busy_vec[addr] && !(hit0 || hit1);
    if (ZERO_REG && (addr == '0)) begin
      data = '0;
      busy = 1'b0;
    end else if (hit1) begin
      data = wb1_data;
    end else if (hit0) begin
      data = wb0_data;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Flip-flop register file with two writeback ports, NRD bypassed read ports and a busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = NRD_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS*XLEN-1:0] regs_q;
  logic [NREGS*XLEN-1:0] regs_d;
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [NREGS-1:0]      we0;
  logic [NREGS-1:0]      we1;
  logic [NREGS-1:0]      set;
  logic [XLEN-1:0]       rd_data_c [NRD];
  logic                  rd_busy_c [NRD];

  // per-register write/issue strobes; register 0 masked when hardwired
  always_comb begin
    we0 = '0;
    we1 = '0;
    set = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      we0[i] = bus.wb0_valid && (bus.wb0_rd == AW'(i));
      we1[i] = bus.wb1_valid && (bus.wb1_rd == AW'(i));
      set[i] = bus.iss_valid && (bus.iss_rd == AW'(i));
    end
    if (ZERO_REG) begin
      we0[0] = 1'b0;
      we1[0] = 1'b0;
      set[0] = 1'b0;
    end
  end

  // next array and scoreboard: wb1 wins a same-register collision, a new issue beats a writeback
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (we1[i]) begin
        regs_d[i*XLEN +: XLEN] = bus.wb1_data;
      end else if (we0[i]) begin
        regs_d[i*XLEN +: XLEN] = bus.wb0_data;
      end
    end
    busy_d = (busy_q & ~(we0 | we1)) | set;
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .addr      (bus.rd_addr[k*AW +: AW]),
      .regs      (regs_q),
      .busy_vec  (busy_q),
      .wb0_valid (bus.wb0_valid),
      .wb0_rd    (bus.wb0_rd),
      .wb0_data  (bus.wb0_data),
      .wb1_valid (bus.wb1_valid),
      .wb1_rd    (bus.wb1_rd),
      .wb1_data  (bus.wb1_data),
      .data      (rd_data_c[k]),
      .busy      (rd_busy_c[k])
    );
  end

  // pack the read ports onto the bus
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      bus.rd_data[k*XLEN +: XLEN] = rd_data_c[k];
      bus.rd_busy[k]              = rd_busy_c[k];
    end
  end

  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one DUT with register 0 hardwired, one without, driven by identical stimulus.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bz1 ();
  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bz0 ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1)) u_z1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bz1)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b0)) u_z0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bz0)
  );

  assign bz0.rd_addr   = bz1.rd_addr;
  assign bz0.iss_valid = bz1.iss_valid;
  assign bz0.iss_rd    = bz1.iss_rd;
  assign bz0.wb0_valid = bz1.wb0_valid;
  assign bz0.wb0_rd    = bz1.wb0_rd;
  assign bz0.wb0_data  = bz1.wb0_data;
  assign bz0.wb1_valid = bz1.wb1_valid;
  assign bz0.wb1_rd    = bz1.wb1_rd;
  assign bz0.wb1_data  = bz1.wb1_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr();
    bz1.iss_valid = 1'b0;
    bz1.wb0_valid = 1'b0;
    bz1.wb1_valid = 1'b0;
  endtask

  task automatic rd(input int k, input logic [4:0] a);
    bz1.rd_addr[k*5 +: 5] = a;
  endtask

  task automatic iss(input logic [4:0] r);
    bz1.iss_valid = 1'b1;
    bz1.iss_rd    = r;
  endtask

  task automatic wb0(input logic [4:0] r, input logic [31:0] d);
    bz1.wb0_valid = 1'b1;
    bz1.wb0_rd    = r;
    bz1.wb0_data  = d;
  endtask

  task automatic wb1(input logic [4:0] r, input logic [31:0] d);
    bz1.wb1_valid = 1'b1;
    bz1.wb1_rd    = r;
    bz1.wb1_data  = d;
  endtask

  function automatic logic [31:0] d1(input int k);
    return bz1.rd_data[k*32 +: 32];
  endfunction

  function automatic logic [31:0] d0(input int k);
    return bz0.rd_data[k*32 +: 32];
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bz1.rd_addr  = '0;
    bz1.iss_rd   = '0;
    bz1.wb0_rd   = '0;
    bz1.wb0_data = '0;
    bz1.wb1_rd   = '0;
    bz1.wb1_data = '0;
    clr();
    rd(0, x5);
    rd(1, x7);
    #2;
    check("reset_busy_vec", bz1.busy_vec, 32'h0);
    check("reset_rd_data0", d1(0), 32'h0);
    check("reset_rd_busy", 32'(bz1.rd_busy), 32'h0);
    cyc();
    reset = 1'b0;

    // write x5 via wb0, bypass then array read
    wb0(x5, 32'hDEAD_BEEF);
    #1;
    check("x5_bypass", d1(0), 32'hDEAD_BEEF);
    cyc(); clr(); #1;
    check("x5_array", d1(0), 32'hDEAD_BEEF);
    check("x5_busy", 32'(bz1.rd_busy[0]), 32'h0);

    // both ports to x7: wb1 wins bypass and array
    wb0(x7, 32'h11);
    wb1(x7, 32'h22);
    #1;
    check("x7_bypass_wb1", d1(1), 32'h22);
    cyc(); clr(); #1;
    check("x7_array_wb1", d1(1), 32'h22);

    // both ports to distinct registers
    wb0(x10, 32'hA0);
    wb1(x11, 32'hB1);
    rd(0, x10);
    rd(1, x11);
    cyc(); clr(); #1;
    check("dual_wr_x10", d1(0), 32'hA0);
    check("dual_wr_x11", d1(1), 32'hB1);

    // issue x3; same-cycle issue invisible, next cycle busy, writeback bypass clears busy
    iss(x3);
    rd(0, x3);
    #1;
    check("x3_same_cycle_busy", 32'(bz1.rd_busy[0]), 32'h0);
    cyc(); clr(); #1;
    check("x3_rd_busy", 32'(bz1.rd_busy[0]), 32'h1);
    check("x3_busy_vec", 32'(bz1.busy_vec[3]), 32'h1);
    wb0(x3, 32'h5);
    #1;
    check("x3_bypass_data", d1(0), 32'h5);
    check("x3_bypass_busy", 32'(bz1.rd_busy[0]), 32'h0);
    check("x3_busy_vec_held", 32'(bz1.busy_vec[3]), 32'h1);
    cyc(); clr(); #1;
    check("x3_busy_cleared", 32'(bz1.busy_vec[3]), 32'h0);
    check("x3_array", d1(0), 32'h5);

    // issue and wb1 to x9 in the same cycle: new producer wins
    iss(x9);
    wb1(x9, 32'hA);
    rd(1, x9);
    cyc(); clr(); #1;
    check("x9_busy_set", 32'(bz1.busy_vec[9]), 32'h1);
    check("x9_array", d1(1), 32'hA);
    check("x9_rd_busy", 32'(bz1.rd_busy[1]), 32'h1);

    // WAW issue keeps bit set; one writeback clears it
    iss(x9);
    cyc(); clr(); #1;
    check("x9_waw", 32'(bz1.busy_vec[9]), 32'h1);
    wb0(x9, 32'hB);
    cyc(); clr(); #1;
    check("x9_wb_clear", 32'(bz1.busy_vec[9]), 32'h0);

    // writeback to a non-busy register
    wb0(x12, 32'h77);
    rd(0, x12);
    cyc(); clr(); #1;
    check("x12_nonbusy_data", d1(0), 32'h77);
    check("x12_nonbusy_bit", 32'(bz1.busy_vec[12]), 32'h0);

    // register 0: hardwired vs ordinary
    wb0(x0, 32'hFFFF_FFFF);
    iss(x0);
    rd(0, x0);
    #1;
    check("z1_x0_bypass", d1(0), 32'h0);
    check("z0_x0_bypass", d0(0), 32'hFFFF_FFFF);
    cyc(); clr(); #1;
    check("z1_x0_read", d1(0), 32'h0);
    check("z1_x0_busy", 32'(bz1.busy_vec[0]), 32'h0);
    check("z0_x0_read", d0(0), 32'hFFFF_FFFF);
    check("z0_x0_busy", 32'(bz0.busy_vec[0]), 32'h1);

    // load x1..x31, issue x4, then reset between edges
    for (int i = 1; i < 32; i++) begin
      wb0(5'(i), 32'h1000_0000 + 32'(i));
      cyc();
    end
    clr();
    iss(x4);
    rd(0, x1);
    rd(1, x31);
    cyc(); clr(); #1;
    check("load_x1", d1(0), 32'h1000_0001);
    check("load_x31", d1(1), 32'h1000_001F);
    check("load_x4_busy", 32'(bz1.busy_vec[4]), 32'h1);
    reset = 1'b1;
    #1;
    check("rst_busy_vec_z1", bz1.busy_vec, 32'h0);
    check("rst_busy_vec_z0", bz0.busy_vec, 32'h0);
    check("rst_x1", d1(0), 32'h0);
    check("rst_x31", d1(1), 32'h0);

    // during reset: bypass visible, write and issue ignored
    wb1(x6, 32'h66);
    iss(x6);
    rd(0, x6);
    #1;
    check("rst_bypass_data", d1(0), 32'h66);
    check("rst_bypass_busy", 32'(bz1.rd_busy[0]), 32'h0);
    cyc(); clr(); #1;
    check("rst_wr_ignored", d1(0), 32'h0);
    check("rst_iss_ignored", bz1.busy_vec, 32'h0);

    // first edge after release behaves normally
    reset = 1'b0;
    wb0(x2, 32'h2);
    rd(1, x2);
    cyc(); clr(); #1;
    check("post_rst_write", d1(1), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 2; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, read port count; range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 hardwires register 0 to zero.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 rd_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-008 rd_data  out  NRD*XLEN  read data, packed the same way.
REQ-009 rd_busy  out  NRD  1 = register at port k has an outstanding producer.
REQ-010 iss_valid  in  1  issue strobe; marks iss_rd pending.
REQ-011 iss_rd  in  AW  destination register being issued.
REQ-012 wb0_valid / wb0_rd / wb0_data  in  1 / AW / XLEN  writeback port 0.
REQ-013 wb1_valid / wb1_rd / wb1_data  in  1 / AW / XLEN  writeback port 1; higher priority.
REQ-014 busy_vec  out  NREGS  registered scoreboard, bit i = register i pending.

Function
REQ-015 Each read port SHALL be combinational; priority: ZERO_REG and addr 0 -> 0; else wb1 match -> wb1_data; else wb0 match -> wb0_data; else array content.
REQ-016 A "match" SHALL be wbN_valid=1 and wbN_rd = rd_addr[k]; the bypass is zero-latency.
REQ-017 The array SHALL update at the clock edge when wbN_valid=1; both ports to different registers -> both written.
REQ-018 Both write ports to the same register in one cycle -> only wb1_data is stored.
REQ-019 ZERO_REG=1: writes to register 0 ignored, reads return 0, busy_vec[0] stays 0, issue to 0 ignored.
REQ-020 ZERO_REG=0: register 0 behaves as any other register.
REQ-021 Scoreboard: iss_valid sets busy_vec[iss_rd] at next edge; wbN_valid clears busy_vec[wbN_rd] at next edge.
REQ-022 Issue and writeback to the same register in the same cycle -> bit SHALL end set (new producer wins).
REQ-023 Issue to an already-busy register (WAW) SHALL keep the bit set; no count kept.
REQ-024 Writeback to a non-busy register SHALL still write data; bit remains 0.
REQ-025 rd_busy[k] = busy_vec[rd_addr[k]] AND NOT (any wb match on port k); bypassed data is never reported busy.
REQ-026 rd_busy[k] SHALL NOT reflect a same-cycle issue; the issue takes effect from the next cycle.
REQ-027 No output other than rd_data / rd_busy SHALL depend combinationally on inputs.

Reset
REQ-028 reset=1 SHALL immediately, independent of clk, clear all NREGS registers to 0 and busy_vec to 0.
REQ-029 While reset=1, writes and issues SHALL be ignored; rd_data reads 0 and rd_busy reads 0, except through the wb bypass.
REQ-030 Deasserting reset mid-program SHALL lose all pending state; the first edge after deassertion behaves normally.

Structure
REQ-031 The shared package SHALL hold the default XLEN/NREGS values and the register-name constants x0..x31.
REQ-032 One sub-module, regfile_sb_rdport, SHALL implement a single read port with bypass and busy mask; instantiate it NRD times via generate.
REQ-033 Storage SHALL be a flip-flop array, not inferred RAM, to permit asynchronous reset.

Verification
REQ-034 Write x5=0xDEADBEEF via wb0; next cycle read x5 on port 0 -> 0xDEADBEEF, rd_busy[0]=0.
REQ-035 Same cycle: wb0 x7=0x11, wb1 x7=0x22, read x7 -> 0x22 combinationally; after edge array x7=0x22.
REQ-036 Issue x3; next cycle rd_busy=1 and busy_vec[3]=1; wb0 x3=0x5 -> same cycle rd_data=0x5, rd_busy=0; next cycle busy_vec[3]=0.
REQ-037 Issue x9 and wb1 x9=0xA in the same cycle -> busy_vec[9]=1 afterwards, array x9=0xA.
REQ-038 ZERO_REG=1: wb0 x0=0xFFFF_FFFF plus issue x0 -> reads 0, busy_vec[0]=0; ZERO_REG=0 rerun -> reads 0xFFFF_FFFF.
REQ-039 Load x1..x31 with values, issue x4, assert reset between edges -> all reads 0 and busy_vec=0 immediately.
